// File: rtl/lmsm_sequencer_pkg.sv
// Shared definitions for the LM/SM micro-sequencer: opcodes, instruction
// field positions, sequencer state encoding and a small opcode helper.
package lmsm_sequencer_pkg;

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int RA_MSB   = 11;
  localparam int RA_LSB   = 9;
  localparam int MASK_MSB = 7;
  localparam int MASK_LSB = 0;
  // Opcode LSB distinguishes SM (1) from LM (0).
  localparam int SM_BIT   = 12;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_e;

  // True for the two multi-register opcodes this block sequences.
  function automatic logic is_lmsm(input logic [3:0] opc);
    return (opc == OP_LM) || (opc == OP_SM);
  endfunction

endpackage

// File: rtl/lmsm_sequencer_prio_enc8.sv
// prio_enc8: index of the lowest set bit of an 8-bit mask, plus a flag that
// is high when exactly one bit remains set.
module prio_enc8 (
  input  logic [7:0] mask_i,
  output logic [2:0] idx_o,
  output logic       single_o
);

  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    idx_o = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_i[i]) idx_o = 3'(i);
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest bit leaves nothing.
  assign single_o = (mask_i != 8'd0) && ((mask_i & (mask_i - 8'd1)) == 8'd0);

endmodule

// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: decode-stage micro-sequencer for LM/SM. Stalls IF/ID,
// then issues one register/memory transfer per cycle for each set bit of
// IR[7:0], lowest first, at consecutive addresses from the base register.
// Optional feature macro: LMSM_R7_REDIRECT_EN (r7_loaded pulse on LM of R7).
module lmsm_sequencer
  import lmsm_sequencer_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [15:0]       ir,
  input  logic [ADDR_W-1:0] base_data,
  input  logic              mem_ready,
  output logic [2:0]        base_ra,
  output logic              active,
  output logic              stall,
  output logic [2:0]        xfer_reg,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              done,
  output logic              r7_loaded
);

  localparam int CNT_W = $clog2(NREG + 1);

  state_e              state_q;
  logic [NREG-1:0]     mask_q;
  logic                is_sm_q;
  logic [ADDR_W-1:0]   base_q;
  logic [CNT_W-1:0]    count_q;

  logic [NREG-1:0]     mask_d;
  logic [2:0]          low_idx;
  logic                last_bit;
  logic                accept;
  logic                in_xfer;
  logic                xfer_go;
  logic                last_acc;
  logic                unused_ir_bit;

  // Bit 8 of the instruction is not part of RA, opcode or mask.
  assign unused_ir_bit = ir[8];

  prio_enc8 u_prio (
    .mask_i   (mask_q),
    .idx_o    (low_idx),
    .single_o (last_bit)
  );

  assign base_ra = ir[RA_MSB:RA_LSB];

  // A zero mask is a NOP and never enters the sequencer.
  assign accept = (state_q == S_IDLE) && !reset && !flush && valid_in &&
                  is_lmsm(ir[OPC_MSB:OPC_LSB]) &&
                  (ir[MASK_MSB:MASK_LSB] != '0);

  // Reset aborts immediately, so it masks everything the XFER state drives.
  assign in_xfer  = (state_q == S_XFER) && !reset;
  // A flush kills the transfer presented in its own cycle.
  assign xfer_go  = in_xfer && !flush;
  assign last_acc = xfer_go && mem_ready && last_bit;

  assign mask_d   = mask_q & (mask_q - NREG'(1));

  assign active   = in_xfer;
  assign xfer_reg = in_xfer ? low_idx : 3'd0;
  assign mem_addr = in_xfer ? (base_q + ADDR_W'(count_q)) : '0;
  assign mem_rd   = xfer_go && !is_sm_q;
  assign mem_wr   = xfer_go && is_sm_q;
  assign done     = last_acc;
  // Stall releases in the cycle the final transfer is accepted so the next
  // instruction can enter decode right away.
  assign stall    = accept || (xfer_go && !last_acc);

  // Sequencer FSM: latch the instruction on accept, retire one mask bit per
  // accepted transfer, return to IDLE after the last one or on flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      is_sm_q <= 1'b0;
      base_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q <= S_XFER;
            mask_q  <= ir[MASK_MSB:MASK_LSB];
            is_sm_q <= ir[SM_BIT];
            base_q  <= base_data;
            count_q <= '0;
          end
        end
        S_XFER: begin
          if (mem_ready) begin
            mask_q  <= mask_d;
            count_q <= count_q + CNT_W'(1);
            if (last_bit) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef LMSM_R7_REDIRECT_EN
  logic r7_q;

  // Remember whether this LM loads R7 so fetch can redirect when it completes.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r7_q <= 1'b0;
    end else if (accept) begin
      r7_q <= ir[MASK_MSB] && !ir[SM_BIT];
    end
  end

  assign r7_loaded = last_acc && !is_sm_q && r7_q;
`else
  assign r7_loaded = 1'b0;
`endif

endmodule
